rx_frame_controller: RTL and testbench

Sequences the UART receive datapath. Drives its receive enable, consumes each received byte on its done pulse, and parses framed packets of the form header, length, payload, checksum. Buffers the payload locally and holds it for a downstream consumer (LoongArch-side peripheral logic) until acknowledged. Detects length, timeout and checksum errors and re-arms the receiver.

---
 rtl/rx_frame_controller.sv | 215 +++++++++++++++++++++
 tb/tb_rx_frame_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_controller.sv
// ============================================================================
//  Module      : rx_frame_controller
//  Description : Framed UART receive sequencer (header, length, payload,
//                checksum) with a local payload buffer held until acknowledged.
//                Optional statistics counters enabled by RX_FRAME_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_controller #(
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HEADER      = 8'hAA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RX_Done_Sig,
    input  logic [7:0]  RX_Data,
    output logic        RX_En_Sig,
    output logic        Frame_Valid,
    output logic [7:0]  Frame_Len,
    input  logic [7:0]  Rd_Addr,
    output logic [7:0]  Rd_Data,
    input  logic        Frame_Ack,
    output logic        Err_Sig,
    output logic [1:0]  Err_Code,
    output logic [15:0] Good_Cnt,
    output logic [15:0] Err_Cnt
);

    localparam int           c_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int           c_TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [8:0]   c_MAX_LEN = 9'(MAX_LEN);

    localparam logic [1:0]   c_ERR_LEN  = 2'b01;
    localparam logic [1:0]   c_ERR_TMO  = 2'b10;
    localparam logic [1:0]   c_ERR_CSUM = 2'b11;

    localparam logic [2:0]   c_ST_IDLE    = 3'd0;
    localparam logic [2:0]   c_ST_LEN     = 3'd1;
    localparam logic [2:0]   c_ST_PAYLOAD = 3'd2;
    localparam logic [2:0]   c_ST_CSUM    = 3'd3;
    localparam logic [2:0]   c_ST_HOLD    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [7:0]         r_len;
    logic [7:0]         r_idx;
    logic [7:0]         r_csum;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic [7:0]         r_frame_len;
    logic               r_err_sig;
    logic [1:0]         r_err_code;
    logic [7:0]         r_rd_data;
    logic [7:0]         r_buf [MAX_LEN];

    logic               w_in_frame;
    logic               w_tmo;
    logic               w_err_evt;
    logic [1:0]         w_err_code;
    logic               w_good_evt;
    logic               w_wr_en;

    assign w_in_frame = (r_state == c_ST_LEN) || (r_state == c_ST_PAYLOAD) ||
                        (r_state == c_ST_CSUM);
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_tmo      = w_in_frame && !RX_Done_Sig && (r_tmo_cnt == c_TMO_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_err_evt   = 1'b0;
        w_err_code  = 2'b00;
        w_good_evt  = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (RX_Done_Sig && (RX_Data == HEADER)) begin
                    w_state_nxt = c_ST_LEN;
                end
            end
            c_ST_LEN: begin
                if (RX_Done_Sig) begin
                    if ({1'b0, RX_Data} > c_MAX_LEN) begin
                        w_err_evt   = 1'b1;
                        w_err_code  = c_ERR_LEN;
                        w_state_nxt = c_ST_IDLE;
                    end else if (RX_Data == 8'd0) begin
                        w_state_nxt = c_ST_CSUM;
                    end else begin
                        w_state_nxt = c_ST_PAYLOAD;
                    end
                end
            end
            c_ST_PAYLOAD: begin
                if (RX_Done_Sig) begin
                    w_wr_en = 1'b1;
                    if (r_idx == (r_len - 8'd1)) begin
                        w_state_nxt = c_ST_CSUM;
                    end
                end
            end
            c_ST_CSUM: begin
                if (RX_Done_Sig) begin
                    if (RX_Data == r_csum) begin
                        w_good_evt  = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end else begin
                        w_err_evt   = 1'b1;
                        w_err_code  = c_ERR_CSUM;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_HOLD: begin
                if (Frame_Ack) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
        if (w_tmo) begin
            w_err_evt   = 1'b1;
            w_err_code  = c_ERR_TMO;
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_ST_IDLE;
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_csum      <= 8'd0;
            r_tmo_cnt   <= '0;
            r_frame_len <= 8'd0;
            r_err_sig   <= 1'b0;
            r_err_code  <= 2'b00;
            r_rd_data   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_sig <= w_err_evt;
            if (w_err_evt) begin
                r_err_code <= w_err_code;
            end
            if ((r_state == c_ST_LEN) && RX_Done_Sig) begin
                r_len  <= RX_Data;
                r_csum <= RX_Data;
                r_idx  <= 8'd0;
            end
            if (w_wr_en) begin
                r_csum <= r_csum + RX_Data;
                r_idx  <= r_idx + 8'd1;
            end
            if (w_good_evt) begin
                r_frame_len <= r_len;
            end
            // Counter is held at zero outside a frame, which also clears it on entry to LEN.
            if (w_in_frame && !RX_Done_Sig && !w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if ({1'b0, Rd_Addr} < c_MAX_LEN) begin
                r_rd_data <= r_buf[Rd_Addr[c_AW-1:0]];
            end else begin
                r_rd_data <= 8'd0;
            end
        end
    end

    // Payload storage carries no reset; writes occur only while receiving payload.
    always_ff @(posedge CLK) begin
        if (w_wr_en && ({1'b0, r_idx} < c_MAX_LEN)) begin
            r_buf[r_idx[c_AW-1:0]] <= RX_Data;
        end
    end

`ifdef RX_FRAME_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_good_cnt <= 16'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            if (w_good_evt && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign Good_Cnt = r_good_cnt;
    assign Err_Cnt  = r_err_cnt;
`else
    assign Good_Cnt = 16'd0;
    assign Err_Cnt  = 16'd0;
`endif

    assign RX_En_Sig   = (r_state != c_ST_HOLD);
    assign Frame_Valid = (r_state == c_ST_HOLD);
    assign Frame_Len   = r_frame_len;
    assign Rd_Data     = r_rd_data;
    assign Err_Sig     = r_err_sig;
    assign Err_Code    = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_controller.sv
// ============================================================================
//  Module      : tb_rx_frame_controller
//  Description : Directed self-checking bench for rx_frame_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_controller;

    localparam int c_MAX_LEN = 16;
    localparam int c_TMO     = 100;

    logic        CLK;
    logic        RST;
    logic        RX_Done_Sig;
    logic [7:0]  RX_Data;
    logic        RX_En_Sig;
    logic        Frame_Valid;
    logic [7:0]  Frame_Len;
    logic [7:0]  Rd_Addr;
    logic [7:0]  Rd_Data;
    logic        Frame_Ack;
    logic        Err_Sig;
    logic [1:0]  Err_Code;
    logic [15:0] Good_Cnt;
    logic [15:0] Err_Cnt;

    int n_pass;
    int n_chk;
    int n_wait;

    rx_frame_controller #(
        .MAX_LEN     (c_MAX_LEN),
        .TIMEOUT_CYC (c_TMO),
        .HEADER      (8'hAA)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_Done_Sig (RX_Done_Sig),
        .RX_Data     (RX_Data),
        .RX_En_Sig   (RX_En_Sig),
        .Frame_Valid (Frame_Valid),
        .Frame_Len   (Frame_Len),
        .Rd_Addr     (Rd_Addr),
        .Rd_Data     (Rd_Data),
        .Frame_Ack   (Frame_Ack),
        .Err_Sig     (Err_Sig),
        .Err_Code    (Err_Code),
        .Good_Cnt    (Good_Cnt),
        .Err_Cnt     (Err_Cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    // Presents one byte for a single cycle; returns at the negedge after capture.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_Data     = b;
        RX_Done_Sig = 1'b1;
        @(negedge CLK);
        RX_Done_Sig = 1'b0;
    endtask

    task automatic ack_frame();
        @(negedge CLK);
        Frame_Ack = 1'b1;
        @(negedge CLK);
        Frame_Ack = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp_v);
        @(negedge CLK);
        Rd_Addr = addr;
        @(negedge CLK);
        chk(tag, {24'd0, Rd_Data}, {24'd0, exp_v});
    endtask

    initial begin
        n_pass      = 0;
        n_chk       = 0;
        RST         = 1'b1;
        RX_Done_Sig = 1'b0;
        RX_Data     = 8'h00;
        Rd_Addr     = 8'h00;
        Frame_Ack   = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        chk("rst_rx_en",   {31'd0, RX_En_Sig},   32'd1);
        chk("rst_valid",   {31'd0, Frame_Valid}, 32'd0);
        chk("rst_len",     {24'd0, Frame_Len},   32'd0);
        chk("rst_rd_data", {24'd0, Rd_Data},     32'd0);
        chk("rst_err",     {29'd0, Err_Sig, Err_Code}, 32'd0);
        chk("rst_cnts",    {Good_Cnt, Err_Cnt},  32'd0);

        // Good 3-byte frame
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        chk("f1_valid", {31'd0, Frame_Valid}, 32'd1);
        chk("f1_len",   {24'd0, Frame_Len},   32'd3);
        chk("f1_rx_en", {31'd0, RX_En_Sig},   32'd0);
        read_chk("f1_rd0", 8'd0, 8'h11);
        read_chk("f1_rd1", 8'd1, 8'h22);
        read_chk("f1_rd2", 8'd2, 8'h33);
        read_chk("f1_rd_oob", 8'd20, 8'h00);
        // Bytes during HOLD are ignored
        send_byte(8'hAA); send_byte(8'h05);
        chk("f1_hold_valid", {31'd0, Frame_Valid}, 32'd1);
        chk("f1_hold_len",   {24'd0, Frame_Len},   32'd3);
        read_chk("f1_hold_rd0", 8'd0, 8'h11);
        ack_frame();
        chk("f1_ack_valid", {31'd0, Frame_Valid}, 32'd0);
        chk("f1_ack_rx_en", {31'd0, RX_En_Sig},   32'd1);

        // Junk byte then zero-length frame
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00);
        chk("f2_valid", {31'd0, Frame_Valid}, 32'd1);
        chk("f2_len",   {24'd0, Frame_Len},   32'd0);
        ack_frame();

        // Length error
        send_byte(8'hAA); send_byte(8'h11);
        chk("lenerr_sig",   {31'd0, Err_Sig},     32'd1);
        chk("lenerr_code",  {30'd0, Err_Code},    32'd1);
        chk("lenerr_valid", {31'd0, Frame_Valid}, 32'd0);
        @(negedge CLK);
        chk("lenerr_pulse", {31'd0, Err_Sig},     32'd0);
        chk("lenerr_hold",  {30'd0, Err_Code},    32'd1);

        // Checksum error
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h02); send_byte(8'h00);
        chk("csum_sig",   {31'd0, Err_Sig},   32'd1);
        chk("csum_code",  {30'd0, Err_Code},  32'd3);
        chk("csum_rx_en", {31'd0, RX_En_Sig}, 32'd1);

        // Timeout: error appears exactly c_TMO cycles after the last byte
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
        n_wait = 0;
        for (int i = 1; i <= c_TMO + 10; i++) begin
            @(negedge CLK);
            if (Err_Sig) begin
                n_wait = i;
                break;
            end
        end
        chk("tmo_cycles", n_wait, c_TMO);
        chk("tmo_code",   {30'd0, Err_Code}, 32'd2);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        chk("f3_valid", {31'd0, Frame_Valid}, 32'd1);
        chk("f3_len",   {24'd0, Frame_Len},   32'd1);
        read_chk("f3_rd0", 8'd0, 8'h7F);
        ack_frame();

        // Reset mid-payload
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
        Rd_Addr = 8'd0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("mid_rst_rx_en", {31'd0, RX_En_Sig},   32'd1);
        chk("mid_rst_valid", {31'd0, Frame_Valid}, 32'd0);
        chk("mid_rst_len",   {24'd0, Frame_Len},   32'd0);
        chk("mid_rst_rd",    {24'd0, Rd_Data},     32'd0);
        chk("mid_rst_err",   {29'd0, Err_Sig, Err_Code}, 32'd0);
        // Remaining payload bytes are now stray bytes in IDLE
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h77);
        chk("post_rst_idle", {31'd0, Frame_Valid}, 32'd0);
        chk("post_rst_noerr", {31'd0, Err_Sig},    32'd0);

        // One good frame plus one error for the statistics counters
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
        chk("f4_valid", {31'd0, Frame_Valid}, 32'd1);
        ack_frame();
        send_byte(8'hAA); send_byte(8'h20);
        chk("f5_code", {30'd0, Err_Code}, 32'd1);
`ifdef RX_FRAME_STATS_EN
        chk("good_cnt", {16'd0, Good_Cnt}, 32'd1);
        chk("err_cnt",  {16'd0, Err_Cnt},  32'd1);
`else
        chk("good_cnt", {16'd0, Good_Cnt}, 32'd0);
        chk("err_cnt",  {16'd0, Err_Cnt},  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
